// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 matrix keypad scanner with frame-based debounce
module keypad_scan #(
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_down
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE - 1);
    localparam logic [CW-1:0] DB_MAX     = CW'(DEBOUNCE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS_DB,
        S_HELD,
        S_REL_DB
    } state_t;

    logic [PW-1:0] presc_q;
    logic [1:0]    idx_q;
    logic [3:0]    row_q;
    logic [3:0]    sync1_q;
    logic [3:0]    sync2_q;
    logic [11:0]   frame_q;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    cand_q;
    logic [3:0]    key_q;
    logic          valid_q;
    logic          down_q;

    logic          tick;
    logic          frame_end;
    logic [15:0]   frame_d;
    logic [4:0]    nzero;
    logic [3:0]    zidx;
    logic          f_empty;
    logic          f_single;

    // Slot tick, frame assembly (row 3 taken live) and zero-bit classification
    always_comb begin
        tick      = (presc_q == PRESC_LAST);
        frame_end = tick && (idx_q == 2'd3);
        frame_d   = {sync2_q, frame_q};
        nzero     = '0;
        zidx      = '0;
        for (int i = 0; i < 16; i++) begin
            if (!frame_d[i]) begin
                nzero = nzero + 5'd1;
                zidx  = 4'(i);
            end
        end
        f_empty  = (nzero == 5'd0);
        f_single = (nzero == 5'd1);
    end

    // Column synchronizer, prescaler, row drive and per-row sample capture
    always_ff @(posedge clk) begin
        if (clr) begin
            presc_q <= '0;
            idx_q   <= 2'd0;
            row_q   <= 4'b1110;
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
            frame_q <= '1;
        end else begin
            sync1_q <= col;
            sync2_q <= sync1_q;
            if (tick) begin
                presc_q <= '0;
                idx_q   <= idx_q + 2'd1;
                row_q   <= ~(4'b0001 << (idx_q + 2'd1));
                case (idx_q)
                    2'd0:    frame_q[3:0]  <= sync2_q;
                    2'd1:    frame_q[7:4]  <= sync2_q;
                    2'd2:    frame_q[11:8] <= sync2_q;
                    default: ;
                endcase
            end else begin
                presc_q <= presc_q + PW'(1);
            end
        end
    end

    // Press/release debounce FSM, stepped once per full-scan frame
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cand_q  <= '0;
            key_q   <= '0;
            valid_q <= 1'b0;
            down_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (frame_end) begin
                case (state_q)
                    S_IDLE: begin
                        if (f_single) begin
                            cand_q <= zidx;
                            if (DEBOUNCE == 1) begin
                                cnt_q   <= DB_MAX;
                                key_q   <= zidx;
                                down_q  <= 1'b1;
                                valid_q <= 1'b1;
                                state_q <= S_HELD;
                            end else begin
                                cnt_q   <= CW'(1);
                                state_q <= S_PRESS_DB;
                            end
                        end
                    end
                    S_PRESS_DB: begin
                        if (f_single && (zidx == cand_q)) begin
                            if (cnt_q == DB_LAST) begin
                                cnt_q   <= DB_MAX;
                                key_q   <= cand_q;
                                down_q  <= 1'b1;
                                valid_q <= 1'b1;
                                state_q <= S_HELD;
                            end else begin
                                cnt_q <= cnt_q + CW'(1);
                            end
                        end else if (f_single) begin
                            cand_q <= zidx;
                            cnt_q  <= CW'(1);
                        end else begin
                            cnt_q   <= '0;
                            state_q <= S_IDLE;
                        end
                    end
                    S_HELD: begin
                        // Any non-empty frame, including rollover, keeps the held key
                        if (f_empty) begin
                            if (DEBOUNCE == 1) begin
                                cnt_q   <= '0;
                                down_q  <= 1'b0;
                                state_q <= S_IDLE;
                            end else begin
                                cnt_q   <= CW'(1);
                                state_q <= S_REL_DB;
                            end
                        end
                    end
                    S_REL_DB: begin
                        if (f_empty) begin
                            if (cnt_q == DB_LAST) begin
                                cnt_q   <= '0;
                                down_q  <= 1'b0;
                                state_q <= S_IDLE;
                            end else begin
                                cnt_q <= cnt_q + CW'(1);
                            end
                        end else begin
                            state_q <= S_HELD;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign row       = row_q;
    assign key       = key_q;
    assign key_valid = valid_q;
    assign key_down  = down_q;

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - self-checking bench for keypad_scan
module tb_keypad_scan;

    localparam int SD = 4;
    localparam int DB = 3;

    logic        clk;
    logic        clr;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [3:0]  key;
    logic        key_valid;
    logic        key_down;
    logic [15:0] keys;

    int n_run;
    int n_fail;

    keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
        .clk       (clk),
        .clr       (clr),
        .col       (col),
        .row       (row),
        .key       (key),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix: a held key (r,c) pulls column c low while row r is driven low
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (row[r] == 1'b0 && keys[r*4+c]) col[c] = 1'b0;
    end

    // Reference model: cycle counter, 2-cycle input delay, per-frame key sets and run lengths
    int          m_cyc, m_run, m_r, m_nz, m_k;
    logic [15:0] m_p1, m_p2, m_frame, m_rm;
    logic [3:0]  m_cand, exp_key, exp_row;
    logic        exp_valid, exp_down;

    always @(posedge clk) begin
        if (clr) begin
            m_cyc = 0; m_run = 0; m_p1 = 16'h0; m_p2 = 16'h0; m_frame = 16'h0; m_cand = 4'h0;
            exp_key = 4'h0; exp_valid = 1'b0; exp_down = 1'b0; exp_row = 4'b1110;
        end else begin
            exp_valid = 1'b0;
            if (m_cyc % SD == SD - 1) begin
                m_r = (m_cyc / SD) % 4;
                m_rm = 16'h000F << (4 * m_r);
                m_frame = m_frame | (m_p2 & m_rm);
                if (m_r == 3) begin
                    m_nz = $countones(m_frame);
                    m_k = 0;
                    for (int i = 0; i < 16; i++) if (m_frame[i]) m_k = i;
                    if (!exp_down) begin
                        if (m_nz == 1) begin
                            if (m_run > 0 && m_k == int'(m_cand)) m_run++;
                            else begin m_cand = 4'(m_k); m_run = 1; end
                        end else m_run = 0;
                        if (m_run == DB) begin
                            exp_key = m_cand; exp_down = 1'b1; exp_valid = 1'b1; m_run = 0;
                        end
                    end else begin
                        if (m_nz == 0) m_run++; else m_run = 0;
                        if (m_run == DB) begin exp_down = 1'b0; m_run = 0; end
                    end
                    m_frame = 16'h0;
                end
            end
            m_p2 = m_p1;
            m_p1 = keys;
            m_cyc++;
            exp_row = ~(4'b0001 << ((m_cyc / SD) % 4));
        end
    end

    function automatic logic [15:0] rand_keys();
        int sel;
        logic [15:0] v;
        v = 16'h0;
        sel = $urandom_range(0, 19);
        if (sel >= 8 && sel < 17) v[$urandom_range(0, 15)] = 1'b1;
        else if (sel >= 17) begin
            v[$urandom_range(0, 15)] = 1'b1;
            v[$urandom_range(0, 15)] = 1'b1;
        end
        return v;
    endfunction

    // Two reset edges, release in cycle 0, then an optional idle gap to shift the scan phase
    task automatic do_reset(input int gap);
        @(negedge clk);
        clr = 1'b1; keys = 16'h0;
        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic test_reset();
        clr = 1'b1; keys = 16'h0;
        @(negedge clk);
        n_run++;
        if (row !== 4'b1110) begin n_fail++; $display("FAIL reset_row got=%b exp=1110", row); end
        keys = 16'(($urandom & 16'hFFFF) | 16'h0001);
        repeat (3) @(negedge clk);
        n_run++;
        if ({row, key, key_valid, key_down} !== {4'b1110, 4'h0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_hold got row=%b key=%h v=%b d=%b exp 1110/0/0/0", row, key, key_valid, key_down);
        end
        keys = 16'h0;
    endtask

    task automatic test_row_wrap();
        logic [3:0] seq [4];
        int pulses;
        seq[0] = 4'b1110; seq[1] = 4'b1101; seq[2] = 4'b1011; seq[3] = 4'b0111;
        pulses = 0;
        do_reset(0);
        n_run++;
        if (row !== 4'b1110) begin n_fail++; $display("FAIL wrap_c0 got=%b exp=1110", row); end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n_run++;
            if (row !== seq[((i + 1) / SD) % 4]) begin
                n_fail++; $display("FAIL wrap_row cyc=%0d got=%b exp=%b", i + 1, row, seq[((i + 1) / SD) % 4]);
            end
            if (key_valid === 1'b1) pulses++;
        end
        n_run++;
        if ({pulses != 0, key, key_down} !== 6'b0) begin
            n_fail++; $display("FAIL wrap_idle got pulses=%0d key=%h d=%b exp 0/0/0", pulses, key, key_down);
        end
    endtask

    task automatic test_clean_press();
        int pulses, first;
        pulses = 0; first = -1;
        do_reset(0);
        keys = 16'h0200;
        for (int i = 0; i < 67; i++) begin
            @(negedge clk);
            n_run++;
            if ({row, key, key_valid, key_down} !== {exp_row, exp_key, exp_valid, exp_down}) begin
                n_fail++;
                $display("FAIL press_model cyc=%0d got %b/%h/%b/%b exp %b/%h/%b/%b", i + 1,
                         row, key, key_valid, key_down, exp_row, exp_key, exp_valid, exp_down);
            end
            if (key_valid === 1'b1) begin pulses++; if (first < 0) first = i + 1; end
        end
        n_run++;
        if (pulses != 1 || key !== 4'h9 || key_down !== 1'b1 || first < 2 * 4 * SD || first > 67) begin
            n_fail++; $display("FAIL press_accept got pulses=%0d key=%h d=%b at=%0d exp 1/9/1 by 67", pulses, key, key_down, first);
        end
        keys = 16'h0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            n_run++;
            if ({row, key, key_valid, key_down} !== {exp_row, exp_key, exp_valid, exp_down}) begin
                n_fail++;
                $display("FAIL release_model got %b/%h/%b/%b exp %b/%h/%b/%b",
                         row, key, key_valid, key_down, exp_row, exp_key, exp_valid, exp_down);
            end
            if (key_valid === 1'b1) pulses++;
        end
        n_run++;
        if (pulses != 1 || key_down !== 1'b0 || key !== 4'h9) begin
            n_fail++; $display("FAIL release got pulses=%0d d=%b key=%h exp 1/0/9", pulses, key_down, key);
        end
    endtask

    // Phase-table scenario runner state is local to each task; checks are inline per task
    task automatic test_bounce();
        int pulses;
        pulses = 0;
        do_reset($urandom_range(0, 15));
        for (int ph = 0; ph < 7; ph++) begin
            keys = (ph == 6 || ph % 2 == 0) ? 16'h0008 : 16'h0000;
            for (int i = 0; i < ((ph == 6) ? 80 : 10); i++) begin
                @(negedge clk);
                n_run++;
                if ({row, key, key_valid, key_down} !== {exp_row, exp_key, exp_valid, exp_down}) begin
                    n_fail++;
                    $display("FAIL bounce_model ph=%0d got %b/%h/%b/%b exp %b/%h/%b/%b", ph,
                             row, key, key_valid, key_down, exp_row, exp_key, exp_valid, exp_down);
                end
                if (key_valid === 1'b1) pulses++;
            end
        end
        n_run++;
        if (pulses != 1 || key !== 4'h3 || key_down !== 1'b1) begin
            n_fail++; $display("FAIL bounce got pulses=%0d key=%h d=%b exp 1/3/1", pulses, key, key_down);
        end
    endtask

    task automatic test_multi_key();
        logic [15:0] pk [2];
        int          ep [2];
        logic        ed [2];
        int pulses;
        pk[0] = 16'h0041; ep[0] = 0; ed[0] = 1'b0;
        pk[1] = 16'h0001; ep[1] = 1; ed[1] = 1'b1;
        pulses = 0;
        do_reset($urandom_range(0, 15));
        for (int ph = 0; ph < 2; ph++) begin
            keys = pk[ph];
            for (int i = 0; i < 80; i++) begin
                @(negedge clk);
                n_run++;
                if ({row, key, key_valid, key_down} !== {exp_row, exp_key, exp_valid, exp_down}) begin
                    n_fail++;
                    $display("FAIL multi_model ph=%0d got %b/%h/%b/%b exp %b/%h/%b/%b", ph,
                             row, key, key_valid, key_down, exp_row, exp_key, exp_valid, exp_down);
                end
                if (key_valid === 1'b1) pulses++;
            end
            n_run++;
            if (pulses != ep[ph] || key_down !== ed[ph] || key !== 4'h0) begin
                n_fail++; $display("FAIL multi ph=%0d got pulses=%0d d=%b key=%h exp %0d/%b/0", ph, pulses, key_down, key, ep[ph], ed[ph]);
            end
        end
    endtask

    task automatic test_rollover();
        logic [15:0] pk [5];
        int          pn [5];
        int          ep [5];
        logic [3:0]  ek [5];
        logic        ed [5];
        int pulses;
        pk[0] = 16'h8000; pn[0] = 80;  ep[0] = 1; ek[0] = 4'hF; ed[0] = 1'b1;
        pk[1] = 16'h8020; pn[1] = 32;  ep[1] = 1; ek[1] = 4'hF; ed[1] = 1'b1;
        pk[2] = 16'h0020; pn[2] = 100; ep[2] = 1; ek[2] = 4'hF; ed[2] = 1'b1;
        pk[3] = 16'h0000; pn[3] = 80;  ep[3] = 1; ek[3] = 4'hF; ed[3] = 1'b0;
        pk[4] = 16'h0020; pn[4] = 80;  ep[4] = 2; ek[4] = 4'h5; ed[4] = 1'b1;
        pulses = 0;
        do_reset($urandom_range(0, 15));
        for (int ph = 0; ph < 5; ph++) begin
            keys = pk[ph];
            for (int i = 0; i < pn[ph]; i++) begin
                @(negedge clk);
                n_run++;
                if ({row, key, key_valid, key_down} !== {exp_row, exp_key, exp_valid, exp_down}) begin
                    n_fail++;
                    $display("FAIL roll_model ph=%0d got %b/%h/%b/%b exp %b/%h/%b/%b", ph,
                             row, key, key_valid, key_down, exp_row, exp_key, exp_valid, exp_down);
                end
                if (key_valid === 1'b1) pulses++;
            end
            n_run++;
            if (pulses != ep[ph] || key !== ek[ph] || key_down !== ed[ph]) begin
                n_fail++;
                $display("FAIL roll ph=%0d got pulses=%0d key=%h d=%b exp %0d/%h/%b", ph, pulses, key, key_down, ep[ph], ek[ph], ed[ph]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int pulses, first;
        pulses = 0; first = -1;
        do_reset(0);
        keys = 16'h0010;
        repeat ($urandom_range(20, 40)) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        n_run++;
        if ({row, key, key_valid, key_down} !== {4'b1110, 4'h0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_reset got row=%b key=%h v=%b d=%b exp 1110/0/0/0", row, key, key_valid, key_down);
        end
        clr = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            n_run++;
            if ({row, key, key_valid, key_down} !== {exp_row, exp_key, exp_valid, exp_down}) begin
                n_fail++;
                $display("FAIL mid_model cyc=%0d got %b/%h/%b/%b exp %b/%h/%b/%b", i + 1,
                         row, key, key_valid, key_down, exp_row, exp_key, exp_valid, exp_down);
            end
            if (key_valid === 1'b1) begin pulses++; if (first < 0) first = i + 1; end
        end
        n_run++;
        if (pulses != 1 || first != 3 * 4 * SD || key !== 4'h4 || key_down !== 1'b1) begin
            n_fail++; $display("FAIL mid_requal got pulses=%0d at=%0d key=%h d=%b exp 1/48/4/1", pulses, first, key, key_down);
        end
    endtask

    task automatic test_random_traffic();
        int len;
        do_reset($urandom_range(0, 15));
        for (int s = 0; s < 40; s++) begin
            keys = rand_keys();
            len = $urandom_range(1, 80);
            for (int i = 0; i < len; i++) begin
                @(negedge clk);
                n_run++;
                if ({row, key, key_valid, key_down} !== {exp_row, exp_key, exp_valid, exp_down}) begin
                    n_fail++;
                    $display("FAIL random seg=%0d keys=%h got %b/%h/%b/%b exp %b/%h/%b/%b", s, keys,
                             row, key, key_valid, key_down, exp_row, exp_key, exp_valid, exp_down);
                end
            end
        end
        keys = 16'h0;
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        clr    = 1'b1;
        keys   = 16'h0;
        test_reset();
        test_row_wrap();
        test_clean_press();
        test_bounce();
        test_multi_key();
        test_rollover();
        test_reset_mid();
        test_random_traffic();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Input-side counterpart to the multiplexed 7-segment display path.
- Scans a 4x4 matrix keypad by driving one row low at a time and reading the columns back.
- Debounces each key and reports a single 4-bit key code with a one-cycle valid strobe.
- Key codes 0..9 feed the counter's `load`/`in` entry path; codes 10..15 are available for commands.

Parameters:
- SCAN_DIV, 50000, clk cycles per row slot; minimum 4 (covers the 2-flop synchronizer latency).
- DEBOUNCE, 4, consecutive identical full-scan frames required to accept a press or a release; minimum 1.

Ports:
- clk  input  1  system clock.
- clr  input  1  reset, synchronous, active-high.
- col  input  4  keypad columns, active-low, externally pulled up, asynchronous to clk.
- row  output 4  keypad rows, active-low; exactly one bit low at all times.
- key  output 4  code of the last accepted key = {row_idx[1:0], col_idx[1:0]}.
- key_valid  output 1  one-cycle pulse when a new key is accepted.
- key_down  output 1  level; high while the accepted key is held (debounced).

Behaviour:
- Reset (clr high at posedge clk) has priority over everything:
  - row = 4'b1110, key = 0, key_valid = 0, key_down = 0.
  - Prescaler = 0, row index = 0, synchronizer flops = 4'b1111, frame accumulator cleared, debounce count = 0, FSM = IDLE.
- Synchronizer: col passes through 2 flops before any use.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - The cycle with prescaler == SCAN_DIV-1 is the slot tick.
- Row scan:
  - On each slot tick the row index advances 0→1→2→3→0.
  - row = ~(1 << idx), registered. Each row is therefore low for exactly SCAN_DIV cycles.
- Sampling:
  - On the slot tick, the synchronized col for the current row is recorded.
  - A pressed column reads 0.
- Frame evaluation: on the slot tick of row 3, the 4 recorded samples form one frame, classified as:
  - EMPTY: no zero bits.
  - SINGLE(k): exactly one zero bit, k = {row, col}.
  - MULTI: two or more zero bits.
- FSM, advanced only on frame-end ticks:
  - IDLE:
    - SINGLE(k): latch candidate k, count = 1, go to PRESS_DB. If DEBOUNCE == 1, accept immediately.
    - EMPTY or MULTI: stay.
  - PRESS_DB:
    - SINGLE(same k): count++. When count reaches DEBOUNCE: key <= k, key_down <= 1, key_valid pulses, go to HELD.
    - SINGLE(different k): restart with the new candidate, count = 1.
    - EMPTY or MULTI: go to IDLE, count = 0.
  - HELD:
    - EMPTY: count = 1, go to REL_DB.
    - SINGLE or MULTI (any key): stay. Second keys and rollover are ignored; key stays unchanged.
  - REL_DB:
    - EMPTY: count++. When count reaches DEBOUNCE: key_down <= 0, go to IDLE.
    - Any non-empty frame: go back to HELD. No new key_valid is generated.
- Output timing:
  - key, key_down and key_valid are registered and change in the cycle after the qualifying frame-end tick.
  - key_valid is high for exactly 1 cycle per accepted press.
  - key holds its value until the next accepted press.
- Latency: a clean press is accepted between DEBOUNCE and DEBOUNCE+1 frames after contact, plus 3 cycles. One frame = 4*SCAN_DIV cycles.
- Widths: prescaler is $clog2(SCAN_DIV) bits; debounce counter is $clog2(DEBOUNCE+1) bits and saturates at DEBOUNCE.
- Reset mid-debounce or mid-hold: all progress is discarded. A key still held after reset must re-qualify over DEBOUNCE full frames, then pulses key_valid once.

Test Plan:
All scenarios use SCAN_DIV=4, DEBOUNCE=3. The bench keypad model drives col[c]=0 whenever row[r]==0 and key (r,c) is held.
1. Row wrap: release clr, hold no keys → row sequence 1110,1101,1011,0111,1110, each lasting 4 cycles; key_valid never asserts; key=0, key_down=0.
2. Clean press: hold (2,1) from cycle 0 after reset → exactly one key_valid pulse with key=4'h9, key_down=1 within 4*16+3 cycles. Release → key_down=0 after 3-4 empty frames, with no further pulse.
3. Bounce: toggle key (0,3) every 10 cycles for 60 cycles, then hold stable → exactly one key_valid, key=4'h3.
4. Multi-key: hold (0,0) and (1,2) together from IDLE → no key_valid, key_down stays 0. Release (1,2) while (0,0) is still held → one pulse, key=4'h0.
5. Rollover: hold (3,3) until accepted (key=4'hF), then add (1,1), release (3,3), keep (1,1) → no second pulse until all keys are released for 3 frames and (1,1) is pressed again.
6. Reset mid-operation: pulse clr during PRESS_DB of key (1,0), keep holding → all outputs at reset values, then one key_valid with key=4'h4 after a fresh 3-frame qualification.
